fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch queue between the instruction memory and the dual-issue decoder.
- Each cycle it accepts an aligned pair of instruction words with their PC, and presents the two oldest entries to decode.
- Decode retires 0, 1 or 2 entries per cycle.
- Drives a stall to the PC stage when a full pair cannot be accepted, and discards all contents on a taken jump/branch.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- W, 32, instruction and PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  taken jump/branch from the ALU stage; discard all entries.
- push_valid  in  1  imem pair valid this cycle.
- push_ins0  in  W  instruction at push_pc.
- push_ins1  in  W  instruction at push_pc+1.
- push_pc  in  W  word address of push_ins0.
- push_stall  out  1  queue cannot accept a pair; PC stage holds its PC.
- pop_cnt  in  2  entries decode consumes this cycle (0, 1, 2; 3 treated as 2).
- out_valid0  out  1  head entry valid.
- out_ins0  out  W  head instruction.
- out_pc0  out  W  head PC.
- out_valid1  out  1  second entry valid.
- out_ins1  out  W  second instruction.
- out_pc1  out  W  second PC.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: DEPTH entries of {ins, pc}.
  - Read pointer rd_ptr and write pointer wr_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is held as a separate register.
- Reset (async, rst_n=0):
  - rd_ptr=0, wr_ptr=0, count=0.
  - All out_valid*=0, push_stall=0.
  - Storage contents are don't-care.
- Outputs are first-word-fall-through and purely combinational from registered state:
  - out_*0 = entry[rd_ptr]; out_*1 = entry[rd_ptr+1].
  - out_valid0 = (count>=1); out_valid1 = (count>=2).
  - When the corresponding valid is 0, the ins and pc outputs are driven to 0.
- push_stall = (DEPTH - count) < 2. It depends on registered count only, never on the same-cycle pop_cnt, so there is no combinational path from decode to PC.
- Effective pop: eff_pop = min(pop_cnt clamped to 2, count).
  - Over-pop is silently clamped.
  - In simulation, an over-pop raises a $display warning.
- Push accept: acc = push_valid & ~push_stall.
  - On accept, both words are written: entry[wr_ptr] = {push_ins0, push_pc}; entry[wr_ptr+1] = {push_ins1, push_pc+1}.
  - wr_ptr advances by 2.
  - A push while stalled is ignored; the PC stage re-presents the pair.
- Count update each edge: count <= count + 2*acc - eff_pop. Simultaneous push and pop are legal at any fill level where push is allowed.
- Latency: a pushed pair is visible at the outputs on the cycle after the accepting edge. There is no same-cycle bypass.
- Flush has priority over push and pop:
  - At the edge with flush=1: rd_ptr=wr_ptr=0, count=0.
  - The pushed pair in that cycle is dropped.
  - push_stall deasserts the following cycle.
- Wrap-around: entry+1 indexing wraps modulo DEPTH, so a pair may straddle the end of the storage array.
- Full: count==DEPTH-1 or DEPTH asserts push_stall. An odd count is reachable after a single pop.
- Empty: out_valid0=0; pop_cnt is ignored.

Optional Feature:
- FETCHQ_PERF_EN defined:
  - Adds output ports perf_stall_cycles (32) and perf_flushes (32).
  - perf_stall_cycles counts cycles with push_valid & push_stall.
  - perf_flushes counts edges with flush=1.
  - Both reset to 0 on rst_n and saturate at all-ones.
- Not defined: ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - INS_W=32.
  - Opcode constants already used by decode (OP_RTYPE=6'b000000, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_JAL=6'b000011, OP_LW=6'b100011, OP_SW=6'b101011, FN_JR=6'b001000).
  - The pop count encoding (POP_NONE, POP_ONE, POP_TWO).
- One sub-module, fetchq_mem: a DEPTH×(2W) register array with two write ports (consecutive addresses) and two read ports, with no reset. The pointer, count and flush logic stays in fetch_queue.

Test Plan:
- Reset then idle: rst_n low → count=0, out_valid0=out_valid1=0, push_stall=0; after release with no push, the state is unchanged.
- Push pair {0x01095020, 0x8D280004} at pc=0x10, pop_cnt=0 → next cycle count=2, out_pc0=0x10, out_pc1=0x11, out_ins1=0x8D280004.
- Push 4 pairs with no pop (DEPTH=8) → count=8, push_stall=1; a 5th push is ignored; pop_cnt=1 leaves count=7 with push_stall still 1; pop_cnt=2 gives count=5 and push_stall=0.
- Steady state with push every cycle and pop_cnt=2 across 20 cycles → count stays 2, out_pc0 increments by 2 per cycle, and wrap past index 7 yields correct ordering.
- flush=1 with count=6 and simultaneous push_valid=1, pop_cnt=2 → next cycle count=0, out_valid0=0, and the dropped pair never appears.
- count=1 with pop_cnt=2 → count=0, no underflow, rd_ptr advances by 1, warning printed; rst_n asserted mid-stream clears everything asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, decode opcodes and the
// decode-to-fetch-queue pop count encoding.
package cpu_pkg;

    localparam int INS_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_e;

    // Decode may drive 3; it means "as many as possible", i.e. two.
    function automatic logic [1:0] pop_clamp(input logic [1:0] p);
        return (p == 2'd3) ? 2'(POP_TWO) : p;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: imem pair push side, flush, and the two-entry decode view.
interface fetch_queue_if #(
    parameter int DEPTH = 8,
    parameter int W     = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          push_valid;
    logic [W-1:0]  push_ins0;
    logic [W-1:0]  push_ins1;
    logic [W-1:0]  push_pc;
    logic          push_stall;
    logic [1:0]    pop_cnt;
    logic          out_valid0;
    logic [W-1:0]  out_ins0;
    logic [W-1:0]  out_pc0;
    logic          out_valid1;
    logic [W-1:0]  out_ins1;
    logic [W-1:0]  out_pc1;
    logic [CW-1:0] count;

    modport master (
        output flush, push_valid, push_ins0, push_ins1, push_pc, pop_cnt,
        input  push_stall, out_valid0, out_ins0, out_pc0,
               out_valid1, out_ins1, out_pc1, count
    );

    modport slave (
        input  flush, push_valid, push_ins0, push_ins1, push_pc, pop_cnt,
        output push_stall, out_valid0, out_ins0, out_pc0,
               out_valid1, out_ins1, out_pc1, count
    );

endinterface

// File: rtl/fetchq_mem.sv
// Fetch queue storage: DEPTH x {ins,pc}, two writes to consecutive
// addresses and two reads (addr, addr+1), both wrapping. No reset.
module fetchq_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [2*W-1:0]  wdata0,
    input  logic [2*W-1:0]  wdata1,
    input  logic [AW-1:0]   raddr,
    output logic [2*W-1:0]  rdata0,
    output logic [2*W-1:0]  rdata1
);

    logic [DEPTH-1:0][2*W-1:0] mem;
    logic [AW-1:0]             waddr1;
    logic [AW-1:0]             raddr1;

    assign waddr1 = waddr + 1'b1;
    assign raddr1 = raddr + 1'b1;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr]  <= wdata0;
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem[raddr];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue with FWFT two-entry head view.
// Optional FETCHQ_PERF_EN adds saturating stall/flush performance counters.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = INS_W
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef FETCHQ_PERF_EN
    output logic [31:0]  perf_stall_cycles,
    output logic [31:0]  perf_flushes,
`endif
    fetch_queue_if.slave fq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count_q, count_nxt;
    logic [CW-1:0]  pop_req, eff_pop, push_add;
    logic           stall, acc, over_pop;
    logic [2*W-1:0] rdata0, rdata1;

    // Stall looks only at registered occupancy: no decode-to-PC comb path.
    assign stall    = count_q > CW'(DEPTH - 2);
    assign acc      = fq.push_valid & ~stall;
    assign pop_req  = CW'(pop_clamp(fq.pop_cnt));
    assign over_pop = pop_req > count_q;
    assign eff_pop  = over_pop ? count_q : pop_req;
    assign push_add = acc ? CW'(2) : '0;
    assign count_nxt = count_q + push_add - eff_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (fq.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr + eff_pop[AW-1:0];
            wr_ptr  <= wr_ptr + push_add[AW-1:0];
            count_q <= count_nxt;
        end
    end

    fetchq_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
        .clk    (clk),
        .we     (acc & ~fq.flush),
        .waddr  (wr_ptr),
        .wdata0 ({fq.push_ins0, fq.push_pc}),
        .wdata1 ({fq.push_ins1, fq.push_pc + W'(1)}),
        .raddr  (rd_ptr),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    assign fq.push_stall = stall;
    assign fq.count      = count_q;
    assign fq.out_valid0 = count_q != '0;
    assign fq.out_valid1 = count_q >= CW'(2);
    assign fq.out_ins0   = fq.out_valid0 ? rdata0[2*W-1:W] : '0;
    assign fq.out_pc0    = fq.out_valid0 ? rdata0[W-1:0]   : '0;
    assign fq.out_ins1   = fq.out_valid1 ? rdata1[2*W-1:W] : '0;
    assign fq.out_pc1    = fq.out_valid1 ? rdata1[W-1:0]   : '0;

`ifdef FETCHQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (fq.push_valid && stall && !(&perf_stall_cycles))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (fq.flush && !(&perf_flushes))
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && !fq.flush && over_pop)
            $display("fetch_queue warning: over-pop, pop_cnt=%0d count=%0d", fq.pop_cnt, count_q);
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int W     = 32;

    typedef struct packed {
        logic [W-1:0] ins;
        logic [W-1:0] pc;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    entry_t q[$];

    fetch_queue_if #(.DEPTH(DEPTH), .W(W)) fq ();

`ifdef FETCHQ_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flushes;
    fetch_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
        .fq(fq));
`else
    fetch_queue #(.DEPTH(DEPTH), .W(W)) dut (.clk(clk), .rst_n(rst_n), .fq(fq));
`endif

    always #5 clk = ~clk;

    task automatic drive(input logic fl, input logic pv, input logic [W-1:0] i0,
                         input logic [W-1:0] i1, input logic [W-1:0] pc, input logic [1:0] pop);
        fq.flush = fl; fq.push_valid = pv; fq.push_ins0 = i0; fq.push_ins1 = i1;
        fq.push_pc = pc; fq.pop_cnt = pop;
    endtask

    // Reference: a FIFO of entries; pops from the front, pushes a pair at the back.
    task automatic model_step();
        int sz, req, e;
        sz  = q.size();
        req = (fq.pop_cnt == 2'd3) ? 2 : int'(fq.pop_cnt);
        if (fq.flush) begin
            q.delete();
        end else begin
            e = (req < sz) ? req : sz;
            repeat (e) void'(q.pop_front());
            if (fq.push_valid && (DEPTH - sz) >= 2) begin
                q.push_back('{ins: fq.push_ins0, pc: fq.push_pc});
                q.push_back('{ins: fq.push_ins1, pc: fq.push_pc + 1});
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, 2'd0);
    endtask

    task automatic do_flush();
        drive(1'b1, 1'b0, '0, '0, '0, 2'd0);
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        n_chk++; if (fq.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fq.count); end
        n_chk++; if (fq.out_valid0 !== 1'b0 || fq.out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b%b exp=00", fq.out_valid0, fq.out_valid1); end
        n_chk++; if (fq.push_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", fq.push_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        cyc(); cyc();
        n_chk++; if (fq.count !== 4'd0 || fq.out_valid0 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset count=%0d v0=%b exp=0,0", fq.count, fq.out_valid0); end
    endtask

    task automatic test_push_pair();
        drive(1'b0, 1'b1, 32'h01095020, 32'h8D280004, 32'h10, 2'd0);
        n_chk++; if (fq.out_valid0 !== 1'b0) begin n_fail++; $display("FAIL no_bypass v0=%b exp=0", fq.out_valid0); end
        cyc();
        idle();
        n_chk++; if (fq.count !== 4'd2) begin n_fail++; $display("FAIL pair_count got=%0d exp=2", fq.count); end
        n_chk++; if (fq.out_pc0 !== 32'h10 || fq.out_pc1 !== 32'h11) begin n_fail++; $display("FAIL pair_pc got=%h,%h exp=10,11", fq.out_pc0, fq.out_pc1); end
        n_chk++; if (fq.out_ins0 !== 32'h01095020 || fq.out_ins1 !== 32'h8D280004) begin n_fail++; $display("FAIL pair_ins got=%h,%h exp=01095020,8d280004", fq.out_ins0, fq.out_ins1); end
    endtask

    task automatic test_full();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, $urandom, $urandom, 32'h20 + 32'(2*i), 2'd0);
            cyc();
        end
        n_chk++; if (fq.count !== 4'd8 || fq.push_stall !== 1'b1) begin n_fail++; $display("FAIL full count=%0d stall=%b exp=8,1", fq.count, fq.push_stall); end
        drive(1'b0, 1'b1, 32'hBAD0, 32'hBAD1, 32'h99, 2'd0);
        cyc();
        n_chk++; if (fq.count !== 4'd8 || fq.out_pc0 !== 32'h20) begin n_fail++; $display("FAIL push_while_full count=%0d pc0=%h exp=8,20", fq.count, fq.out_pc0); end
        drive(1'b0, 1'b0, '0, '0, '0, 2'd1);
        cyc();
        n_chk++; if (fq.count !== 4'd7 || fq.push_stall !== 1'b1 || fq.out_pc0 !== 32'h21) begin n_fail++; $display("FAIL pop1_full count=%0d stall=%b pc0=%h exp=7,1,21", fq.count, fq.push_stall, fq.out_pc0); end
        drive(1'b0, 1'b0, '0, '0, '0, 2'd2);
        cyc();
        idle();
        n_chk++; if (fq.count !== 4'd5 || fq.push_stall !== 1'b0 || fq.out_pc0 !== 32'h23) begin n_fail++; $display("FAIL pop2_full count=%0d stall=%b pc0=%h exp=5,0,23", fq.count, fq.push_stall, fq.out_pc0); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pc;
        do_flush();
        drive(1'b0, 1'b1, $urandom, $urandom, 32'h100, 2'd0);
        cyc();
        for (int i = 1; i <= 20; i++) begin
            pc = 32'h100 + 32'(2*i);
            drive(1'b0, 1'b1, $urandom, $urandom, pc, 2'd2);
            cyc();
            n_chk++; if (fq.count !== 4'd2 || fq.out_pc0 !== pc || fq.out_pc1 !== pc + 1) begin n_fail++; $display("FAIL steady_%0d count=%0d pc0=%h pc1=%h exp=2,%h,%h", i, fq.count, fq.out_pc0, fq.out_pc1, pc, pc + 1); end
            n_chk++; if (fq.out_ins0 !== q[0].ins || fq.out_ins1 !== q[1].ins) begin n_fail++; $display("FAIL steady_ins_%0d got=%h,%h exp=%h,%h", i, fq.out_ins0, fq.out_ins1, q[0].ins, q[1].ins); end
        end
        idle();
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, $urandom, $urandom, 32'h300 + 32'(2*i), 2'd0);
            cyc();
        end
        n_chk++; if (fq.count !== 4'd6) begin n_fail++; $display("FAIL flush_pre count=%0d exp=6", fq.count); end
        drive(1'b1, 1'b1, 32'hDEAD0, 32'hDEAD1, 32'hDEAD0, 2'd2);
        cyc();
        idle();
        n_chk++; if (fq.count !== 4'd0 || fq.out_valid0 !== 1'b0 || fq.push_stall !== 1'b0) begin n_fail++; $display("FAIL flush count=%0d v0=%b stall=%b exp=0,0,0", fq.count, fq.out_valid0, fq.push_stall); end
        drive(1'b0, 1'b1, 32'h5, 32'h6, 32'h500, 2'd0);
        cyc();
        idle();
        n_chk++; if (fq.count !== 4'd2 || fq.out_pc0 !== 32'h500 || fq.out_pc1 !== 32'h501) begin n_fail++; $display("FAIL after_flush count=%0d pc0=%h pc1=%h exp=2,500,501", fq.count, fq.out_pc0, fq.out_pc1); end
    endtask

    task automatic test_overpop_async_reset();
        do_flush();
        drive(1'b0, 1'b1, 32'hA, 32'hB, 32'h40, 2'd0);
        cyc();
        drive(1'b0, 1'b0, '0, '0, '0, 2'd1);
        cyc();
        n_chk++; if (fq.count !== 4'd1 || fq.out_pc0 !== 32'h41 || fq.out_valid1 !== 1'b0) begin n_fail++; $display("FAIL odd_count count=%0d pc0=%h v1=%b exp=1,41,0", fq.count, fq.out_pc0, fq.out_valid1); end
        drive(1'b0, 1'b0, '0, '0, '0, 2'd2);
        cyc();
        n_chk++; if (fq.count !== 4'd0 || fq.out_valid0 !== 1'b0) begin n_fail++; $display("FAIL overpop count=%0d v0=%b exp=0,0", fq.count, fq.out_valid0); end
        drive(1'b0, 1'b1, 32'hC, 32'hD, 32'h60, 2'd3);
        cyc();
        n_chk++; if (fq.count !== 4'd2 || fq.out_pc0 !== 32'h60 || fq.out_ins1 !== 32'hD) begin n_fail++; $display("FAIL after_overpop count=%0d pc0=%h ins1=%h exp=2,60,d", fq.count, fq.out_pc0, fq.out_ins1); end
        drive(1'b0, 1'b1, 32'hE, 32'hF, 32'h70, 2'd0);
        cyc();
        idle();
        rst_n = 1'b0;
        #2;
        n_chk++; if (fq.count !== 4'd0 || fq.out_valid0 !== 1'b0 || fq.push_stall !== 1'b0) begin n_fail++; $display("FAIL async_reset count=%0d v0=%b stall=%b exp=0,0,0", fq.count, fq.out_valid0, fq.push_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_random();
        logic [W-1:0] e_ins0, e_pc0, e_ins1, e_pc1;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
                  $urandom, 2'($urandom_range(0, 3)));
            cyc();
            e_ins0 = (q.size() >= 1) ? q[0].ins : '0;
            e_pc0  = (q.size() >= 1) ? q[0].pc  : '0;
            e_ins1 = (q.size() >= 2) ? q[1].ins : '0;
            e_pc1  = (q.size() >= 2) ? q[1].pc  : '0;
            n_chk++; if (int'(fq.count) != q.size()) begin n_fail++; $display("FAIL rnd_count_%0d got=%0d exp=%0d", i, fq.count, q.size()); end
            n_chk++; if (fq.push_stall !== ((DEPTH - q.size()) < 2)) begin n_fail++; $display("FAIL rnd_stall_%0d got=%b exp=%b", i, fq.push_stall, (DEPTH - q.size()) < 2); end
            n_chk++; if (fq.out_valid0 !== (q.size() >= 1) || fq.out_valid1 !== (q.size() >= 2)) begin n_fail++; $display("FAIL rnd_valid_%0d got=%b%b size=%0d", i, fq.out_valid0, fq.out_valid1, q.size()); end
            n_chk++; if (fq.out_ins0 !== e_ins0 || fq.out_pc0 !== e_pc0) begin n_fail++; $display("FAIL rnd_head_%0d got=%h/%h exp=%h/%h", i, fq.out_ins0, fq.out_pc0, e_ins0, e_pc0); end
            n_chk++; if (fq.out_ins1 !== e_ins1 || fq.out_pc1 !== e_pc1) begin n_fail++; $display("FAIL rnd_second_%0d got=%h/%h exp=%h/%h", i, fq.out_ins1, fq.out_pc1, e_ins1, e_pc1); end
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_push_pair();
        test_full();
        test_back_to_back();
        test_flush();
        test_overpop_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
